switch_logic_unit: RTL and testbench

- Parametrised, clocked successor to the fixed four-switch combinational gate block.
- Synchronises and debounces NUM_SW switch inputs plus one mode button.
- Evaluates a runtime-selectable logic function (pass, AND, OR, XOR, majority, popcount) and drives NUM_LED registered LED outputs.
- Sits directly between board switch pins and LED pins in the top level.

---
 rtl/switch_logic_pkg.sv | 31 +++
 rtl/switch_logic_unit_debounce.sv | 57 +++++
 rtl/switch_logic_unit.sv | 116 +++++++++++
 tb/tb_switch_logic_unit.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/switch_logic_pkg.sv
// Shared mode encoding and defaults for the switch logic unit.
// Consumed by the debounce filter and the top-level evaluator.
package switch_logic_pkg;

  localparam int MODE_W = 3;
  localparam int DEBOUNCE_LIMIT_25MHZ = 250000;

  typedef enum logic [MODE_W-1:0] {
    MODE_PASS  = 3'd0,
    MODE_AND   = 3'd1,
    MODE_OR    = 3'd2,
    MODE_XOR   = 3'd3,
    MODE_MAJ   = 3'd4,
    MODE_COUNT = 3'd5
  } mode_e;

  function automatic mode_e next_mode(input mode_e cur);
    mode_e nxt;
    case (cur)
      MODE_PASS:  nxt = MODE_AND;
      MODE_AND:   nxt = MODE_OR;
      MODE_OR:    nxt = MODE_XOR;
      MODE_XOR:   nxt = MODE_MAJ;
      MODE_MAJ:   nxt = MODE_COUNT;
      MODE_COUNT: nxt = MODE_PASS;
      default:    nxt = MODE_PASS;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/switch_logic_unit_debounce.sv
// Two-flop synchroniser followed by a saturating stability counter; the output
// only follows the input after DEBOUNCE_LIMIT consecutive differing samples.
module debounce_filter
  import switch_logic_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = DEBOUNCE_LIMIT_25MHZ
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Raw,
  output logic o_Db
);

  localparam int CNT_W = $clog2(DEBOUNCE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic             sync1_q;
  logic             sync2_q;
  logic             db_q;
  logic             db_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Counter clears on agreement and on acceptance, so it can never wrap.
  always_comb begin
    cnt_d = CNT_ZERO;
    db_d  = db_q;
    if (sync2_q == db_q) begin
      cnt_d = CNT_ZERO;
    end else if (cnt_q == CNT_LAST) begin
      db_d  = sync2_q;
      cnt_d = CNT_ZERO;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Synchroniser, counter and debounced value registers.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= CNT_ZERO;
      db_q    <= 1'b0;
    end else begin
      sync1_q <= i_Raw;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
    end
  end

  assign o_Db = db_q;

endmodule

// File: rtl/switch_logic_unit.sv
// Debounced switch bank feeding a button-selected logic function whose result
// is registered onto the LEDs.
module switch_logic_unit
  import switch_logic_pkg::*;
#(
  parameter int NUM_SW         = 4,
  parameter int NUM_LED        = 4,
  parameter int DEBOUNCE_LIMIT = DEBOUNCE_LIMIT_25MHZ,
  parameter int MAJ_THRESH     = NUM_SW / 2 + 1
) (
  input  logic               i_Clk,
  input  logic               i_Rst_L,
  input  logic [NUM_SW-1:0]  i_Switch,
  input  logic               i_Mode_Btn,
  output logic [NUM_LED-1:0] o_LED,
  output logic [2:0]         o_Mode,
  output logic [NUM_SW-1:0]  o_Sw_Db
);

  localparam int PC_W    = $clog2(NUM_SW + 1);
  localparam int N_PASS  = (NUM_SW < NUM_LED) ? NUM_SW : NUM_LED;
  localparam int LED_MAX = (1 << NUM_LED) - 1;

  logic [NUM_SW-1:0]  sw_db_s;
  logic               btn_db_s;
  logic               btn_prev_q;
  logic               btn_rise_s;
  mode_e              mode_q;
  logic [PC_W-1:0]    pop_s;
  logic [NUM_LED-1:0] led_d;
  logic [NUM_LED-1:0] led_q;

  for (genvar g = 0; g < NUM_SW; g++) begin : g_sw
    debounce_filter #(.DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)) u_sw_db (
      .i_Clk   (i_Clk),
      .i_Rst_L (i_Rst_L),
      .i_Raw   (i_Switch[g]),
      .o_Db    (sw_db_s[g])
    );
  end

  debounce_filter #(.DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)) u_btn_db (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_Raw   (i_Mode_Btn),
    .o_Db    (btn_db_s)
  );

  assign btn_rise_s = btn_db_s & ~btn_prev_q;

  // Mode FSM: one step per debounced press; illegal codes recover to PASS.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      btn_prev_q <= 1'b0;
      mode_q     <= MODE_PASS;
    end else begin
      btn_prev_q <= btn_db_s;
      case (mode_q)
        MODE_PASS, MODE_AND, MODE_OR, MODE_XOR, MODE_MAJ, MODE_COUNT: begin
          if (btn_rise_s) begin
            mode_q <= next_mode(mode_q);
          end else begin
            mode_q <= mode_q;
          end
        end
        default: mode_q <= MODE_PASS;
      endcase
    end
  end

  // Population count of the debounced switches.
  always_comb begin
    pop_s = PC_W'(0);
    for (int i = 0; i < NUM_SW; i++) begin
      pop_s = pop_s + PC_W'(sw_db_s[i]);
    end
  end

  // LED function select.
  always_comb begin
    led_d = {NUM_LED{1'b0}};
    case (mode_q)
      MODE_PASS: begin
        for (int i = 0; i < N_PASS; i++) begin
          led_d[i] = sw_db_s[i];
        end
      end
      MODE_AND:  led_d[0] = &sw_db_s;
      MODE_OR:   led_d[0] = |sw_db_s;
      MODE_XOR:  led_d[0] = ^sw_db_s;
      MODE_MAJ:  led_d[0] = (int'(pop_s) >= MAJ_THRESH);
      MODE_COUNT: begin
        if (int'(pop_s) > LED_MAX) begin
          led_d = {NUM_LED{1'b1}};
        end else begin
          led_d = NUM_LED'(pop_s);
        end
      end
      default:   led_d = {NUM_LED{1'b0}};
    endcase
  end

  // LED output register.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      led_q <= {NUM_LED{1'b0}};
    end else begin
      led_q <= led_d;
    end
  end

  assign o_LED   = led_q;
  assign o_Mode  = mode_q;
  assign o_Sw_Db = sw_db_s;

endmodule

// File: tb/tb_switch_logic_unit.sv
// Directed bench: a 4-switch/4-LED unit plus an 8-switch/2-LED unit for
// popcount saturation, both with a short debounce window.
module tb_switch_logic_unit;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] sw    = 4'b0000;
  logic       btn   = 1'b0;
  logic [3:0] led;
  logic [2:0] mode;
  logic [3:0] swdb;

  logic [7:0] sw2   = 8'h00;
  logic       btn2  = 1'b0;
  logic [1:0] led2;
  logic [2:0] mode2;
  logic [7:0] swdb2;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  switch_logic_unit #(.NUM_SW(4), .NUM_LED(4), .DEBOUNCE_LIMIT(4)) u_dut (
    .i_Clk      (clk),
    .i_Rst_L    (rst_n),
    .i_Switch   (sw),
    .i_Mode_Btn (btn),
    .o_LED      (led),
    .o_Mode     (mode),
    .o_Sw_Db    (swdb)
  );

  switch_logic_unit #(.NUM_SW(8), .NUM_LED(2), .DEBOUNCE_LIMIT(4)) u_dut_sat (
    .i_Clk      (clk),
    .i_Rst_L    (rst_n),
    .i_Switch   (sw2),
    .i_Mode_Btn (btn2),
    .o_LED      (led2),
    .o_Mode     (mode2),
    .o_Sw_Db    (swdb2)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input int sel, input int hold);
    if (sel == 0) btn = 1'b1; else btn2 = 1'b1;
    tick(hold);
    if (sel == 0) btn = 1'b0; else btn2 = 1'b0;
    tick(8);
  endtask

  initial begin
    // Reset and idle
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_led",  32'(led),  32'(4'b0000));
    check_val("rst_mode", 32'(mode), 32'(3'd0));
    check_val("rst_swdb", 32'(swdb), 32'(4'b0000));
    tick(3);
    rst_n = 1'b1;
    tick(10);
    check_val("idle_led",  32'(led),  32'(4'b0000));
    check_val("idle_mode", 32'(mode), 32'(3'd0));

    // PASS latency and glitch rejection
    sw = 4'b1011;
    tick(5);
    check_val("db_early", 32'(swdb), 32'(4'b0000));
    tick(1);
    check_val("db_at6",   32'(swdb), 32'(4'b1011));
    check_val("led_lag",  32'(led),  32'(4'b0000));
    tick(1);
    check_val("led_at7",  32'(led),  32'(4'b1011));
    sw = 4'b1111;
    tick(3);
    sw = 4'b1011;
    tick(10);
    check_val("glitch_db",  32'(swdb), 32'(4'b1011));
    check_val("glitch_led", 32'(led),  32'(4'b1011));

    // Mode cycling and hold behaviour
    for (int k = 1; k <= 6; k++) begin
      press(0, 8);
      check_val("mode_seq", 32'(mode), 32'(k % 6));
    end
    press(0, 100);
    check_val("mode_hold", 32'(mode), 32'(3'd1));

    // Logic functions with switches 1110, then 1111 in COUNT
    sw = 4'b1110;
    tick(10);
    check_val("and_1110", 32'(led), 32'(4'b0000));
    press(0, 8);
    check_val("or_1110",  32'(led), 32'(4'b0001));
    press(0, 8);
    check_val("xor_1110", 32'(led), 32'(4'b0001));
    press(0, 8);
    check_val("maj_1110", 32'(led), 32'(4'b0001));
    press(0, 8);
    check_val("cnt_mode", 32'(mode), 32'(3'd5));
    check_val("cnt_1110", 32'(led), 32'(4'b0011));
    sw = 4'b1111;
    tick(10);
    check_val("cnt_1111", 32'(led), 32'(4'b0100));
    press(0, 8);
    check_val("pass_1111", 32'(led), 32'(4'b1111));

    // Simultaneous button edge and switch change while in OR
    sw = 4'b0000;
    tick(10);
    press(0, 8);
    press(0, 8);
    check_val("or_mode", 32'(mode), 32'(3'd2));
    check_val("or_0000", 32'(led),  32'(4'b0000));
    btn = 1'b1;
    sw  = 4'b1111;
    tick(6);
    check_val("sim_swdb",  32'(swdb), 32'(4'b1111));
    check_val("sim_mode0", 32'(mode), 32'(3'd2));
    tick(1);
    check_val("sim_mode1", 32'(mode), 32'(3'd3));
    tick(1);
    check_val("sim_led",   32'(led),  32'(4'b0000));
    btn = 1'b0;
    tick(10);
    check_val("sim_release", 32'(mode), 32'(3'd3));

    // Saturation on the 8-switch/2-LED unit
    sw2 = 8'h0F;
    tick(10);
    check_val("sat_pass", 32'(led2), 32'(2'b11));
    for (int k = 0; k < 4; k++) press(1, 8);
    check_val("sat_maj",  32'(led2), 32'(2'b00));
    press(1, 8);
    check_val("sat_mode", 32'(mode2), 32'(3'd5));
    check_val("sat_cnt",  32'(led2),  32'(2'b11));

    // Reset mid-operation, then a fresh debounce from zero
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_led",   32'(led),   32'(4'b0000));
    check_val("mid_rst_mode",  32'(mode),  32'(3'd0));
    check_val("mid_rst_swdb",  32'(swdb),  32'(4'b0000));
    check_val("mid_rst_mode2", 32'(mode2), 32'(3'd0));
    check_val("mid_rst_led2",  32'(led2),  32'(2'b00));
    tick(2);
    rst_n = 1'b1;
    tick(5);
    check_val("post_rst_early", 32'(swdb), 32'(4'b0000));
    tick(1);
    check_val("post_rst_db",    32'(swdb), 32'(4'b1111));
    tick(1);
    check_val("post_rst_led",   32'(led),  32'(4'b1111));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
